// File: rtl/systolic_array_os_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sa_pkg
// Brief    : Shared FSM state, sizing helpers and lane slice macro for the
//            output-stationary systolic array.
// Revision : 1.0 - initial release
// ============================================================================
`ifndef SA_LANE
`define SA_LANE(vec, idx, w) vec[(idx)*(w) +: (w)]
`endif

package sa_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    LOAD  = 3'd2,
    FLUSH = 3'd3,
    DRAIN = 3'd4
  } sa_state_e;

  // Zero beats needed to push the last product through the skewed array.
  function automatic int flush_len(input int rows, input int cols);
    return rows + cols - 1;
  endfunction

  function automatic int row_w(input int rows);
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/systolic_array_os_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : systolic_array_os_ctrl_if
// Brief    : Command, operand stream and result stream bundle of the array.
// Revision : 1.0 - initial release
// ============================================================================
interface systolic_array_os_ctrl_if #(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int KLEN_W = 16
);
  import sa_pkg::*;
  localparam int c_row_w = row_w(ROWS);

  logic                   start;
  logic [KLEN_W-1:0]      k_len;
  logic                   signed_en;
  logic                   busy;
  logic                   in_valid;
  logic                   in_ready;
  logic [ROWS*DATA_W-1:0] a_data;
  logic [COLS*DATA_W-1:0] b_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [c_row_w-1:0]     out_row;
  logic [COLS*ACC_W-1:0]  out_data;
  logic                   done;

  modport master (
    output start, k_len, signed_en, in_valid, a_data, b_data, out_ready,
    input  busy, in_ready, out_valid, out_row, out_data, done
  );

  modport slave (
    input  start, k_len, signed_en, in_valid, a_data, b_data, out_ready,
    output busy, in_ready, out_valid, out_row, out_data, done
  );
endinterface
`default_nettype wire

// File: rtl/systolic_array_os_ctrl_pe.sv
`default_nettype none
// ============================================================================
// Module   : sa_pe
// Brief    : One output-stationary processing element with forward registers.
// Revision : 1.0 - initial release
// ============================================================================
module sa_pe
  import sa_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              step,
  input  logic              signed_en,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic [ACC_W-1:0]  acc
);

  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [ACC_W-1:0]  r_acc;
  logic [ACC_W-1:0]  w_a_ext;
  logic [ACC_W-1:0]  w_b_ext;
  logic [ACC_W-1:0]  w_prod;

  // Extending before the multiply gives the correctly extended product mod 2^ACC_W.
  assign w_a_ext = {{(ACC_W-DATA_W){signed_en & a_in[DATA_W-1]}}, a_in};
  assign w_b_ext = {{(ACC_W-DATA_W){signed_en & b_in[DATA_W-1]}}, b_in};
  assign w_prod  = w_a_ext * w_b_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
    end else if (clr) begin
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
    end else if (step) begin
      r_a   <= a_in;
      r_b   <= b_in;
      r_acc <= r_acc + w_prod;
    end
  end

  assign a_out = r_a;
  assign b_out = r_b;
  assign acc   = r_acc;

endmodule
`default_nettype wire

// File: rtl/systolic_array_os_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : systolic_array_os_ctrl
// Brief    : ROWS x COLS output-stationary matmul engine with load/flush/drain
//            sequencing.
// Revision : 1.0 - initial release
// ============================================================================
module systolic_array_os_ctrl
  import sa_pkg::*;
#(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int KLEN_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  systolic_array_os_ctrl_if.slave  bus
);

  localparam int c_flush_len = flush_len(ROWS, COLS);
  localparam int c_fcnt_w    = $clog2(c_flush_len + 1);
  localparam int c_row_w     = row_w(ROWS);

  sa_state_e             r_state;
  sa_state_e             w_next;
  logic [KLEN_W-1:0]     r_k_len;
  logic                  r_signed;
  logic [KLEN_W-1:0]     r_cnt;
  logic [c_fcnt_w-1:0]   r_fcnt;
  logic [c_row_w-1:0]    r_row;
  logic                  r_done;
  logic                  w_clr;
  logic                  w_step;
  logic                  w_last_row;
  logic [ROWS*DATA_W-1:0] w_a_feed;
  logic [COLS*DATA_W-1:0] w_b_feed;

  logic [DATA_W-1:0] w_a_pass [ROWS][COLS+1];
  logic [DATA_W-1:0] w_b_pass [ROWS+1][COLS];
  logic [ACC_W-1:0]  w_acc    [ROWS][COLS];

  assign w_last_row = (r_row == c_row_w'(ROWS - 1));

  always_comb begin
    w_next = r_state;
    w_clr  = 1'b0;
    w_step = 1'b0;
    case (r_state)
      IDLE:  if (bus.start) w_next = CLEAR;
      CLEAR: begin
        w_clr  = 1'b1;
        w_next = (r_k_len != '0) ? LOAD : DRAIN;
      end
      LOAD: if (bus.in_valid) begin
        w_step = 1'b1;
        if (r_cnt == r_k_len - 1'b1) w_next = FLUSH;
      end
      FLUSH: begin
        w_step = 1'b1;
        if (r_fcnt == c_fcnt_w'(c_flush_len - 1)) w_next = DRAIN;
      end
      DRAIN: if (bus.out_ready && w_last_row) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_k_len  <= '0;
      r_signed <= 1'b0;
      r_cnt    <= '0;
      r_fcnt   <= '0;
      r_row    <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= (r_state == DRAIN) && bus.out_ready && w_last_row;
      case (r_state)
        IDLE: if (bus.start) begin
          r_k_len  <= bus.k_len;
          r_signed <= bus.signed_en;
        end
        CLEAR: begin
          r_cnt  <= '0;
          r_fcnt <= '0;
          r_row  <= '0;
        end
        LOAD:  if (bus.in_valid) r_cnt <= r_cnt + 1'b1;
        FLUSH: r_fcnt <= r_fcnt + 1'b1;
        DRAIN: if (bus.out_ready) r_row <= w_last_row ? '0 : r_row + 1'b1;
        default: ;
      endcase
    end
  end

  // Zero beats are injected during FLUSH so trailing products still drain through.
  assign w_a_feed = (r_state == LOAD) ? bus.a_data : '0;
  assign w_b_feed = (r_state == LOAD) ? bus.b_data : '0;

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_a_skew
    if (gi == 0) begin : g_direct
      assign w_a_pass[gi][0] = `SA_LANE(w_a_feed, gi, DATA_W);
    end else begin : g_delay
      logic [DATA_W-1:0] r_dly [gi];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int d = 0; d < gi; d++) r_dly[d] <= '0;
        end else if (w_clr) begin
          for (int d = 0; d < gi; d++) r_dly[d] <= '0;
        end else if (w_step) begin
          r_dly[0] <= `SA_LANE(w_a_feed, gi, DATA_W);
          for (int d = 1; d < gi; d++) r_dly[d] <= r_dly[d-1];
        end
      end
      assign w_a_pass[gi][0] = r_dly[gi-1];
    end
  end

  for (genvar gj = 0; gj < COLS; gj++) begin : g_b_skew
    if (gj == 0) begin : g_direct
      assign w_b_pass[0][gj] = `SA_LANE(w_b_feed, gj, DATA_W);
    end else begin : g_delay
      logic [DATA_W-1:0] r_dly [gj];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int d = 0; d < gj; d++) r_dly[d] <= '0;
        end else if (w_clr) begin
          for (int d = 0; d < gj; d++) r_dly[d] <= '0;
        end else if (w_step) begin
          r_dly[0] <= `SA_LANE(w_b_feed, gj, DATA_W);
          for (int d = 1; d < gj; d++) r_dly[d] <= r_dly[d-1];
        end
      end
      assign w_b_pass[0][gj] = r_dly[gj-1];
    end
  end

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_pe_row
    for (genvar gj = 0; gj < COLS; gj++) begin : g_pe_col
      sa_pe #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
      ) u_pe (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (w_clr),
        .step      (w_step),
        .signed_en (r_signed),
        .a_in      (w_a_pass[gi][gj]),
        .b_in      (w_b_pass[gi][gj]),
        .a_out     (w_a_pass[gi][gj+1]),
        .b_out     (w_b_pass[gi+1][gj]),
        .acc       (w_acc[gi][gj])
      );
    end
  end

  always_comb begin
    bus.out_data = '0;
    if (r_state == DRAIN) begin
      for (int j = 0; j < COLS; j++) `SA_LANE(bus.out_data, j, ACC_W) = w_acc[r_row][j];
    end
  end

  assign bus.busy      = (r_state != IDLE);
  assign bus.in_ready  = (r_state == LOAD);
  assign bus.out_valid = (r_state == DRAIN);
  assign bus.out_row   = r_row;
  assign bus.done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_systolic_array_os_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_array_os_ctrl
// Brief    : Directed self-checking bench for three array configurations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_systolic_array_os_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int          sel;
  logic        start_d, sgn_d, iv_d, or_d;
  logic [15:0] klen_d;
  logic [7:0]  a_lane [6];
  logic [7:0]  b_lane [6];

  int          n_checks = 0;
  int          n_fail   = 0;
  int          A [6][8];
  int          B [8][6];
  logic [63:0] exp_c [6][6];

  logic        obs_busy, obs_ir, obs_ov, obs_done;
  int          obs_row;
  logic [63:0] obs_lane [6];

  systolic_array_os_ctrl_if #(.ROWS(4), .COLS(4), .DATA_W(8), .ACC_W(32), .KLEN_W(16)) bus0 ();
  systolic_array_os_ctrl_if #(.ROWS(4), .COLS(4), .DATA_W(8), .ACC_W(16), .KLEN_W(16)) bus1 ();
  systolic_array_os_ctrl_if #(.ROWS(2), .COLS(6), .DATA_W(8), .ACC_W(32), .KLEN_W(16)) bus2 ();

  systolic_array_os_ctrl #(.ROWS(4), .COLS(4), .DATA_W(8), .ACC_W(32), .KLEN_W(16))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  systolic_array_os_ctrl #(.ROWS(4), .COLS(4), .DATA_W(8), .ACC_W(16), .KLEN_W(16))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  systolic_array_os_ctrl #(.ROWS(2), .COLS(6), .DATA_W(8), .ACC_W(32), .KLEN_W(16))
    dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  assign bus0.start     = start_d && (sel == 0);
  assign bus0.k_len     = klen_d;
  assign bus0.signed_en = sgn_d;
  assign bus0.in_valid  = iv_d;
  assign bus0.out_ready = or_d;
  assign bus0.a_data    = {a_lane[3], a_lane[2], a_lane[1], a_lane[0]};
  assign bus0.b_data    = {b_lane[3], b_lane[2], b_lane[1], b_lane[0]};

  assign bus1.start     = start_d && (sel == 1);
  assign bus1.k_len     = klen_d;
  assign bus1.signed_en = sgn_d;
  assign bus1.in_valid  = iv_d;
  assign bus1.out_ready = or_d;
  assign bus1.a_data    = {a_lane[3], a_lane[2], a_lane[1], a_lane[0]};
  assign bus1.b_data    = {b_lane[3], b_lane[2], b_lane[1], b_lane[0]};

  assign bus2.start     = start_d && (sel == 2);
  assign bus2.k_len     = klen_d;
  assign bus2.signed_en = sgn_d;
  assign bus2.in_valid  = iv_d;
  assign bus2.out_ready = or_d;
  assign bus2.a_data    = {a_lane[1], a_lane[0]};
  assign bus2.b_data    = {b_lane[5], b_lane[4], b_lane[3], b_lane[2], b_lane[1], b_lane[0]};

  always_comb begin
    obs_busy = 1'b0;
    obs_ir   = 1'b0;
    obs_ov   = 1'b0;
    obs_done = 1'b0;
    obs_row  = 0;
    for (int j = 0; j < 6; j++) obs_lane[j] = '0;
    case (sel)
      0: begin
        obs_busy = bus0.busy; obs_ir = bus0.in_ready; obs_ov = bus0.out_valid;
        obs_done = bus0.done; obs_row = int'(bus0.out_row);
        for (int j = 0; j < 4; j++) obs_lane[j] = 64'(bus0.out_data[j*32 +: 32]);
      end
      1: begin
        obs_busy = bus1.busy; obs_ir = bus1.in_ready; obs_ov = bus1.out_valid;
        obs_done = bus1.done; obs_row = int'(bus1.out_row);
        for (int j = 0; j < 4; j++) obs_lane[j] = 64'(bus1.out_data[j*16 +: 16]);
      end
      default: begin
        obs_busy = bus2.busy; obs_ir = bus2.in_ready; obs_ov = bus2.out_valid;
        obs_done = bus2.done; obs_row = int'(bus2.out_row);
        for (int j = 0; j < 6; j++) obs_lane[j] = 64'(bus2.out_data[j*32 +: 32]);
      end
    endcase
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_t1_data();
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++) begin
        A[i][k] = i*4 + k + 1;
        B[k][i] = (k == i) ? 1 : 0;
      end
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) exp_c[i][j] = 64'(A[i][j]);
  endtask

  task automatic fill(input int av, input int bv, input logic [63:0] cv);
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < 6; k++) begin
        A[i][k] = av;
        B[k][i] = bv;
      end
      for (int j = 0; j < 6; j++) exp_c[i][j] = cv;
    end
  endtask

  // Drives one job on the selected DUT; entered and left at #1 after a clock edge.
  task automatic run_job(input int rows, input int cols, input int k, input bit sgn,
                         input bit stall, input bit rnd, input bit poke);
    int beat, row, cyc, held_row;
    bit iv, orr, hs_in, hs_out, prev_hold, saw_ir;
    logic [63:0] held [6];
    check("idle_before_start", obs_busy, 1'b0);
    start_d = 1'b1; klen_d = 16'(k); sgn_d = sgn; iv_d = 1'b0; or_d = 1'b0;
    @(posedge clk); #1;
    start_d = 1'b0;
    check("busy_after_start", obs_busy, 1'b1);
    beat = 0; row = 0; cyc = 0; prev_hold = 1'b0; saw_ir = 1'b0; held_row = 0;
    for (int j = 0; j < 6; j++) held[j] = '0;
    while (row < rows && cyc < 400) begin
      if (obs_ir) saw_ir = 1'b1;
      if (prev_hold) begin
        check("row_stable", 64'(obs_row), 64'(held_row));
        for (int j = 0; j < cols; j++) check($sformatf("data_stable[%0d]", j), obs_lane[j], held[j]);
      end
      iv = obs_ir && (beat < k) && !(stall && (cyc % 2 == 1));
      iv_d = iv;
      for (int i = 0; i < 6; i++) a_lane[i] = iv ? 8'(A[i][beat]) : 8'($urandom);
      for (int j = 0; j < 6; j++) b_lane[j] = iv ? 8'(B[beat][j]) : 8'($urandom);
      orr = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      or_d = orr;
      start_d = poke;
      if (poke) klen_d = 16'd7;
      hs_in  = iv && obs_ir;
      hs_out = obs_ov && orr;
      if (hs_out) begin
        check("out_row", 64'(obs_row), 64'(row));
        for (int j = 0; j < cols; j++) check($sformatf("C[%0d][%0d]", row, j), obs_lane[j], exp_c[row][j]);
      end
      prev_hold = obs_ov && !orr;
      if (prev_hold) begin
        held_row = obs_row;
        for (int j = 0; j < 6; j++) held[j] = obs_lane[j];
      end
      @(posedge clk); #1;
      if (hs_in) beat++;
      if (hs_out) row++;
      cyc++;
    end
    if (cyc >= 400) check("job_timeout", 1'b1, 1'b0);
    start_d = 1'b0; iv_d = 1'b0; or_d = 1'b0;
    check("done_pulse", obs_done, 1'b1);
    check("busy_low_after", obs_busy, 1'b0);
    if (k == 0) check("no_in_ready_k0", saw_ir, 1'b0);
    else        check("beats_taken", 64'(beat), 64'(k));
    if (poke) begin
      @(posedge clk); #1;
      check("done_one_cycle", obs_done, 1'b0);
      check("start_ignored_busy", obs_busy, 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sel = 0; start_d = 1'b0; sgn_d = 1'b0; iv_d = 1'b0; or_d = 1'b0; klen_d = '0;
    for (int i = 0; i < 6; i++) begin a_lane[i] = '0; b_lane[i] = '0; end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", obs_busy, 1'b0);
    check("rst_in_ready", obs_ir, 1'b0);
    check("rst_out_valid", obs_ov, 1'b0);
    check("rst_done", obs_done, 1'b0);
    check("rst_out_row", 64'(obs_row), 64'd0);
    check("rst_out_data", obs_lane[0], 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // T1 then back-to-back T2 (signed and unsigned)
    set_t1_data();
    run_job(4, 4, 4, 1'b0, 1'b0, 1'b0, 1'b0);
    fill(255, 2, 64'hFFFF_FFFA);
    run_job(4, 4, 3, 1'b1, 1'b0, 1'b0, 1'b0);
    fill(255, 2, 64'd1530);
    run_job(4, 4, 3, 1'b0, 1'b0, 1'b0, 1'b0);

    // T3 input stalls and random output backpressure
    set_t1_data();
    run_job(4, 4, 4, 1'b0, 1'b1, 1'b1, 1'b0);

    // T4 empty reduction, then start pokes during a busy job
    fill(0, 0, 64'd0);
    run_job(4, 4, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    set_t1_data();
    run_job(4, 4, 4, 1'b0, 1'b0, 1'b1, 1'b1);

    // T6 reset in the middle of LOAD
    start_d = 1'b1; klen_d = 16'd4; sgn_d = 1'b0;
    @(posedge clk); #1;
    start_d = 1'b0;
    @(posedge clk); #1;
    for (int b = 0; b < 2; b++) begin
      iv_d = 1'b1;
      for (int i = 0; i < 4; i++) begin a_lane[i] = 8'(A[i][b]); b_lane[i] = 8'(B[b][i]); end
      @(posedge clk); #1;
    end
    check("midload_in_ready", obs_ir, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", obs_busy, 1'b0);
    check("midrst_in_ready", obs_ir, 1'b0);
    check("midrst_out_valid", obs_ov, 1'b0);
    check("midrst_done", obs_done, 1'b0);
    check("midrst_out_row", 64'(obs_row), 64'd0);
    iv_d = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_done", obs_done, 1'b0);
    run_job(4, 4, 4, 1'b0, 1'b0, 1'b0, 1'b0);

    // T5 16-bit accumulator wraparound
    sel = 1;
    @(posedge clk); #1;
    fill(255, 255, 64'd64514);
    run_job(4, 4, 2, 1'b0, 1'b0, 1'b0, 1'b0);

    // 2x6 rerun: A=[1 2 3;4 5 6], B[k][j]=k+j
    sel = 2;
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 3; k++) A[i][k] = i*3 + k + 1;
    for (int k = 0; k < 3; k++)
      for (int j = 0; j < 6; j++) B[k][j] = k + j;
    for (int j = 0; j < 6; j++) begin
      exp_c[0][j] = 64'(8 + 6*j);
      exp_c[1][j] = 64'(17 + 15*j);
    end
    exp_c[0][5] = 64'd38;
    exp_c[1][5] = 64'd92;
    run_job(2, 6, 3, 1'b0, 1'b1, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
